// File: rtl/kirby_anim_sequencer_if.sv
// Command handshake between a host / game-logic requester and the Kirby
// animation sequencer.
//   cmd_valid  requester -> sequencer  command request
//   cmd_ready  sequencer -> requester  command accept
//   cmd_op     requester -> sequencer  0 STOP, 1 WALK, 2 JUMP, 3 INFLATE
//   cmd_dir    requester -> sequencer  WALK direction, 0 right / 1 left
interface kirby_anim_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;

  modport master (output cmd_valid, output cmd_op, output cmd_dir, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_op, input  cmd_dir, output cmd_ready);
endinterface

// File: rtl/kirby_anim_sequencer.sv
// Per-frame scene controller for the ray-marched Kirby renderer.
// Takes one-entry animation commands and steps a pose FSM once per frame on
// vblank_tick, so renderer inputs never change during the visible frame.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   vblank_tick   one-cycle pulse at start of vertical blank
//   cmd           command handshake (slave side)
//   pos_x, pos_y  sprite left edge / baseline
//   dir           facing (0 right, 1 left)
//   pose          0 IDLE, 1 WALK, 2 JUMP, 3 INFLATE, 4 DEFLATE
//   puff          inflation level 0..7
//   frame_parity  toggles every vblank_tick
//   busy          high in JUMP / INFLATE / DEFLATE
module kirby_anim_sequencer #(
  parameter int H_ACTIVE    = 640,
  parameter int SPRITE_W    = 64,
  parameter int X_START     = 288,
  parameter int FLOOR_Y     = 400,
  parameter int JUMP_V0     = 12,
  parameter int GRAVITY     = 1,
  parameter int WALK_STEP   = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vblank_tick,
  kirby_anim_sequencer_if.slave      cmd,
  output logic [9:0]                 pos_x,
  output logic [9:0]                 pos_y,
  output logic                       dir,
  output logic [2:0]                 pose,
  output logic [2:0]                 puff,
  output logic                       frame_parity,
  output logic                       busy
);

  localparam logic [9:0]         X_MAX   = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]         FLOOR   = 10'(FLOOR_Y);
  localparam logic signed [11:0] FLOOR_S = 12'(FLOOR_Y);
  localparam logic [9:0]         STEP    = 10'(WALK_STEP);
  localparam int                 HW      = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] OP_STOP = 2'd0;
  localparam logic [1:0] OP_WALK = 2'd1;
  localparam logic [1:0] OP_JUMP = 2'd2;
  localparam logic [1:0] OP_INFL = 2'd3;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_WALK = 3'd1,
    P_JUMP = 3'd2,
    P_INFL = 3'd3,
    P_DEFL = 3'd4
  } pose_e;

  typedef struct packed {
    logic [1:0] op;
    logic       dir;
  } cmd_t;

  pose_e            st;
  logic             pend_vld;
  cmd_t             pend;
  logic signed [7:0] vel;
  logic [HW-1:0]    hold_cnt;
  logic             xfer;

  assign cmd.cmd_ready = ((st == P_IDLE) || (st == P_WALK)) && !pend_vld;
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
  assign pose          = st;

  // Walk step. A freshly consumed WALK steps in its own direction on the
  // consuming tick, so the direction source is muxed here.
  logic        walk_d;
  logic [10:0] x_right;
  logic [9:0]  walk_x;
  logic        walk_dir;

  assign walk_d  = (pend_vld && pend.op == OP_WALK) ? pend.dir : dir;
  assign x_right = {1'b0, pos_x} + {1'b0, STEP};

  always_comb begin
    walk_x   = pos_x;
    walk_dir = walk_d;
    if (!walk_d) begin
      if (x_right > {1'b0, X_MAX}) begin
        walk_x   = X_MAX;
        walk_dir = 1'b1;
      end else begin
        walk_x = x_right[9:0];
      end
    end else begin
      if (pos_x < STEP) begin
        walk_x   = '0;
        walk_dir = 1'b0;
      end else begin
        walk_x = pos_x - STEP;
      end
    end
  end

  // Jump step in signed arithmetic; on the consuming tick the velocity is
  // the launch value rather than the (stale) register.
  logic signed [7:0]  jv;
  logic signed [11:0] y_next;
  logic               land;

  assign jv     = (pend_vld && pend.op == OP_JUMP) ? 8'(JUMP_V0) : vel;
  assign y_next = $signed({2'b00, pos_y}) - $signed({{4{jv[7]}}, jv});
  assign land   = (jv <= 8'sd0) && (y_next >= FLOOR_S);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= P_IDLE;
      pend_vld     <= 1'b0;
      pend         <= '0;
      vel          <= '0;
      hold_cnt     <= '0;
      pos_x        <= 10'(X_START);
      pos_y        <= FLOOR;
      dir          <= 1'b0;
      puff         <= '0;
      frame_parity <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Fill and consume are exclusive: fill needs an empty slot, consume a full one.
      if (xfer) begin
        pend_vld <= 1'b1;
        pend     <= '{op: cmd.cmd_op, dir: cmd.cmd_dir};
      end
      if (vblank_tick) begin
        frame_parity <= ~frame_parity;
        if (pend_vld) begin
          pend_vld <= 1'b0;
          case (pend.op)
            OP_STOP: st <= P_IDLE;
            OP_WALK: begin
              st    <= P_WALK;
              pos_x <= walk_x;
              dir   <= walk_dir;
            end
            OP_JUMP: begin
              st    <= P_JUMP;
              busy  <= 1'b1;
              pos_y <= y_next[9:0];
              vel   <= 8'(JUMP_V0 - GRAVITY);
            end
            OP_INFL: begin
              st       <= P_INFL;
              busy     <= 1'b1;
              puff     <= puff + 3'd1;
              hold_cnt <= '0;
            end
            default: ;
          endcase
        end else begin
          case (st)
            P_WALK: begin
              pos_x <= walk_x;
              dir   <= walk_dir;
            end
            P_JUMP: begin
              if (land) begin
                pos_y <= FLOOR;
                vel   <= '0;
                st    <= P_IDLE;
                busy  <= 1'b0;
              end else begin
                pos_y <= y_next[9:0];
                vel   <= vel - 8'(GRAVITY);
              end
            end
            P_INFL: begin
              if (puff != 3'd7) begin
                puff <= puff + 3'd1;
              end else if (hold_cnt != HW'(HOLD_FRAMES)) begin
                hold_cnt <= hold_cnt + HW'(1);
              end else begin
                st   <= P_DEFL;
                puff <= puff - 3'd1;
              end
            end
            P_DEFL: begin
              if (puff <= 3'd1) begin
                puff <= '0;
                st   <= P_IDLE;
                busy <= 1'b0;
              end else begin
                puff <= puff - 3'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_kirby_anim_sequencer.sv
// Directed bench for kirby_anim_sequencer: reset, jump arc, walk wall bounce,
// inflate/deflate, handshake coinciding with a tick, reset mid-operation.
module tb_kirby_anim_sequencer;
  logic       clk;
  logic       rst_n;
  logic       vblank_tick;
  logic [9:0] pos_x, pos_y;
  logic       dir, frame_parity, busy;
  logic [2:0] pose, puff;
  int         checks = 0;
  int         errors = 0;

  kirby_anim_sequencer_if cif();

  kirby_anim_sequencer #(.HOLD_FRAMES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vblank_tick  (vblank_tick),
    .cmd          (cif),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .dir          (dir),
    .pose         (pose),
    .puff         (puff),
    .frame_parity (frame_parity),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One frame step; returns at the negedge after the stepping posedge.
  task automatic tick();
    @(negedge clk) vblank_tick = 1'b1;
    @(negedge clk) vblank_tick = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic d);
    @(negedge clk);
    chk("send_rdy", cif.cmd_ready, 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_dir   = d;
    @(negedge clk) cif.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    vblank_tick   = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_dir   = 1'b0;

    // Reset: tick during reset is ignored
    repeat (2) @(negedge clk);
    vblank_tick = 1'b1;
    @(negedge clk) vblank_tick = 1'b0;
    chk("rst_par", frame_parity, 0);
    chk("rst_x", pos_x, 288);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", cif.cmd_ready, 1);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_x", pos_x, 288);
    chk("idle_y", pos_y, 400);
    chk("idle_pose", pose, 0);
    chk("idle_puff", puff, 0);
    chk("idle_par", frame_parity, 1);
    chk("idle_rdy", cif.cmd_ready, 1);

    // Jump
    send(2'd2, 1'b0);
    chk("jmp_pend_rdy", cif.cmd_ready, 0);
    chk("jmp_pend_y", pos_y, 400);
    tick();
    chk("jmp_t1_y", pos_y, 388);
    chk("jmp_t1_pose", pose, 2);
    chk("jmp_t1_busy", busy, 1);
    for (int t = 2; t <= 12; t++) tick();
    chk("jmp_t12_y", pos_y, 322);
    tick();
    chk("jmp_t13_y", pos_y, 322);
    chk("jmp_t13_x", pos_x, 288);
    for (int t = 14; t <= 24; t++) tick();
    chk("jmp_t24_y", pos_y, 388);
    chk("jmp_t24_busy", busy, 1);
    chk("jmp_t24_rdy", cif.cmd_ready, 0);
    tick();
    chk("jmp_t25_y", pos_y, 400);
    chk("jmp_t25_pose", pose, 0);
    chk("jmp_t25_busy", busy, 0);
    chk("jmp_t25_rdy", cif.cmd_ready, 1);

    // Walk right to 572, then re-issue WALK right and bounce off the wall
    send(2'd1, 1'b0);
    tick();
    chk("walk_t1_x", pos_x, 290);
    chk("walk_t1_pose", pose, 1);
    repeat (141) tick();
    chk("walk_pre_x", pos_x, 572);
    send(2'd1, 1'b0);
    tick();
    chk("wall_t1_x", pos_x, 574);
    tick();
    chk("wall_t2_x", pos_x, 576);
    chk("wall_t2_dir", dir, 0);
    tick();
    chk("wall_t3_x", pos_x, 576);
    chk("wall_t3_dir", dir, 1);
    tick();
    chk("wall_t4_x", pos_x, 574);
    send(2'd0, 1'b0);
    tick();
    chk("stop_pose", pose, 0);
    tick();
    chk("stop_x", pos_x, 574);

    // Inflate with HOLD_FRAMES = 2
    send(2'd3, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk($sformatf("infl_t%0d_puff", t), puff,
          (t <= 7) ? t : (t <= 9) ? 7 : 16 - t);
      chk($sformatf("infl_t%0d_pose", t), pose,
          (t <= 9) ? 3 : (t < 16) ? 4 : 0);
    end
    chk("infl_busy", busy, 0);
    chk("infl_rdy", cif.cmd_ready, 1);

    // Transfer coinciding with a tick: not consumed by that tick
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd1;
    cif.cmd_dir   = 1'b1;
    vblank_tick   = 1'b1;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    vblank_tick   = 1'b0;
    chk("sim_x", pos_x, 574);
    chk("sim_pose", pose, 0);
    chk("sim_rdy", cif.cmd_ready, 0);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd2;
    @(negedge clk) cif.cmd_valid = 1'b0;
    tick();
    chk("sim_t1_x", pos_x, 572);
    chk("sim_t1_pose", pose, 1);
    chk("sim_t1_dir", dir, 1);
    tick();
    chk("sim_t2_x", pos_x, 570);
    chk("sim_t2_pose", pose, 1);
    chk("sim_t2_y", pos_y, 400);

    // Reset mid-inflate, with a STOP waiting on the bus
    send(2'd0, 1'b0);
    tick();
    send(2'd3, 1'b0);
    repeat (5) tick();
    chk("mid_puff", puff, 5);
    chk("mid_rdy", cif.cmd_ready, 0);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_x", pos_x, 288);
    chk("mrst_y", pos_y, 400);
    chk("mrst_dir", dir, 0);
    chk("mrst_pose", pose, 0);
    chk("mrst_puff", puff, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_par", frame_parity, 0);
    chk("mrst_rdy", cif.cmd_ready, 1);
    @(negedge clk) cif.cmd_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Pending command lost on reset
    send(2'd1, 1'b0);
    chk("lost_pend_rdy", cif.cmd_ready, 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("lost_rdy", cif.cmd_ready, 1);
    tick();
    chk("lost_x", pos_x, 288);
    chk("lost_pose", pose, 0);
    chk("lost_par", frame_parity, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kirby_anim_sequencer.md
# kirby_anim_sequencer

- Per-frame scene controller that configures the ray-marched Kirby renderer.
- Accepts one-entry animation commands from a host or game-logic requester.
- Steps a pose state machine once per frame, at the start of vertical blank.
- Drives the renderer's position, facing, pose and inflation inputs; these stay constant for the whole visible frame, so the renderer never sees a mid-frame change.

## Interface
- H_ACTIVE, 640, visible width in pixels
- SPRITE_W, 64, Kirby bounding width; X_MAX = H_ACTIVE - SPRITE_W = 576
- X_START, 288, reset horizontal position
- FLOOR_Y, 400, ground line and reset vertical position
- JUMP_V0, 12, initial upward velocity in px/frame
- GRAVITY, 1, velocity decrement per frame
- WALK_STEP, 2, horizontal px/frame while walking
- HOLD_FRAMES, 60, frames held at full inflation
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- vblank_tick  in  1  one-cycle pulse on the first cycle of line V_ACTIVE (start of vertical blank)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept
- cmd_op  in  2  0 STOP, 1 WALK, 2 JUMP, 3 INFLATE
- cmd_dir  in  1  WALK direction: 0 = right, 1 = left; ignored for other ops
- pos_x  out  10  sprite left edge, range 0..X_MAX
- pos_y  out  10  sprite baseline, at most FLOOR_Y
- dir  out  1  facing direction
- pose  out  3  0 IDLE, 1 WALK, 2 JUMP, 3 INFLATE, 4 DEFLATE
- puff  out  3  inflation level, 0..7
- frame_parity  out  1  toggles on every vblank_tick; feeds the dither phase
- busy  out  1  high in JUMP, INFLATE or DEFLATE

## Operation
**Command handshake and pending slot**
- A transfer happens when cmd_valid && cmd_ready. The command is stored in a one-entry pending slot.
- cmd_ready = (pose is IDLE or WALK) && pending slot empty.
- A command is consumed only by a vblank_tick. That same tick performs the first step of the new pose.
- A transfer in the same cycle as vblank_tick is not consumed by that tick; it takes effect at the next tick.

**Per-tick behaviour**
- Everything below happens only on a vblank_tick cycle. frame_parity toggles on every tick.
- Pending STOP: pose becomes IDLE; position is held.
- Pending WALK: dir = cmd_dir; pose becomes WALK.
- WALK step, right: pos_x += WALK_STEP. If the result would exceed X_MAX, then pos_x = X_MAX and dir = 1.
- WALK step, left: pos_x -= WALK_STEP. If the result would go below 0, then pos_x = 0 and dir = 0.
- WALK repeats every tick until a new command arrives.
- JUMP:
  - Uses an internal signed 8-bit velocity, loaded with JUMP_V0 on the consuming tick.
  - Each tick: pos_y -= vel, then vel -= GRAVITY.
  - If pos_y - vel >= FLOOR_Y while vel <= 0: pos_y = FLOOR_Y and pose becomes IDLE on that tick.
  - pos_x is frozen during a jump.
- INFLATE:
  - puff += 1 per tick until it reaches 7.
  - Then hold at 7 for HOLD_FRAMES ticks, counted by an internal counter.
  - Then pose becomes DEFLATE.
- DEFLATE: puff -= 1 per tick. On the tick puff reaches 0, pose becomes IDLE.
- IDLE with no pending command: outputs held.
- cmd_op is decoded at acceptance. Commands accepted while busy are impossible because cmd_ready is low.

## Timing
**Reset and latency**
- Reset values: pos_x = X_START, pos_y = FLOOR_Y, dir = 0, pose = IDLE, puff = 0, frame_parity = 0, busy = 0, cmd_ready = 1.
- The internal velocity, hold counter and pending slot are cleared.
- All outputs except cmd_ready are registered. They update on the clk edge that samples vblank_tick = 1 and are visible the next cycle.
- cmd_ready is combinational from state; it falls the cycle after a transfer.
- Command-to-effect latency: the first vblank_tick strictly after the transfer cycle.

**Boundary conditions**
- Asserting rst_n mid-jump or mid-inflate returns immediately to the reset values; any pending command is lost.
- vblank_tick during reset has no effect.
- Back-to-back ticks (test benches) are legal; each tick is one frame step.

## Test plan
- **Reset:** reset, then 3 ticks with no command -> pos_x = 288, pos_y = 400, pose = 0, puff = 0, frame_parity = 1, cmd_ready = 1.
- **Jump:** JUMP accepted, then ticks -> pos_y = 388 after tick 1; 322 after ticks 12 and 13; 400 with pose = IDLE after tick 25; busy low and cmd_ready high only after landing.
- **Walk right, wall bounce:** WALK right from pos_x = 572 -> tick 1: 574; tick 2: 576; tick 3: 576 with dir = 1; tick 4: 574.
- **Inflate:** INFLATE with HOLD_FRAMES = 2 -> puff 1..7 over ticks 1-7; 7 on ticks 8-9; 6..0 on ticks 10-16; pose IDLE after tick 16.
- **Simultaneous handshake and tick:** transfer and vblank_tick in the same cycle -> no change at that tick; effect at the next tick. cmd_ready stays low in between, so a second cmd_valid is not accepted.
- **Reset mid-operation:** rst_n low during inflate (puff = 5) -> all outputs at reset values in the same cycle; a STOP in the pending slot is discarded.
